move_input_ctrl: RTL and testbench
==================================

Name: move_input_ctrl

Overview:
- Turns the debounced left/right/drop switches into Connect4 game commands.
- Edge-detects each switch, auto-repeats held left/right, and arbitrates simultaneous presses.
- Owns the cursor column register and runs a req/ack handshake with the board/game logic for disc drops.
- Sits between the debouncer_switch instances and the game FSM.

Parameters:
- NUM_COLS, 7, number of board columns; cursor range 0..NUM_COLS-1.
- COL_W, 3, width of column fields; must satisfy 2**COL_W >= NUM_COLS.
- REPEAT_DELAY, 25000000, cycles a direction switch must be held before the first auto-repeat move.
- REPEAT_RATE, 10000000, cycles between subsequent auto-repeat moves.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- btn_left  in  1  debounced left switch; synchronous to clk.
- btn_right  in  1  debounced right switch.
- btn_drop  in  1  debounced drop switch.
- game_busy  in  1  game logic cannot accept a drop (animating, win screen, etc.).
- drop_ack  in  1  game logic accepted the pending drop.
- cursor_col  out  COL_W  current cursor column.
- drop_req  out  1  drop request; held until acknowledged.
- drop_col  out  COL_W  column of the pending drop; stable while drop_req=1.

Behaviour:
- Reset: cursor_col=NUM_COLS/2 (3), drop_req=0, drop_col=0, FSM=IDLE, repeat counter=0.
- Reset also sets the edge-detect history registers to 1, so a switch already held through reset does not trigger a press until it is released.
- Edge detect: a press is btn=1 while its prev register=0. prev registers update every cycle.
- A press seen in cycle N takes effect at the clk edge ending cycle N and is visible on outputs in cycle N+1. Latency is 1 cycle.
- Arbitration in a given cycle:
  - drop press wins over left/right.
  - left and right both high means no move; the repeat counter clears.
  - otherwise a left or right press moves the cursor by 1.
- Cursor boundary: decrement at 0 and increment at NUM_COLS-1 saturate (no change) unless WRAP_EN is defined.
- Auto-repeat applies only when exactly one of left/right is high and the FSM is IDLE:
  - The counter counts held cycles after the press.
  - At REPEAT_DELAY, one move fires and the counter reloads.
  - After that, a move fires every REPEAT_RATE cycles.
  - The counter clears on release, on the both-pressed case, and on any FSM exit from IDLE.
  - Drop never repeats.
- FSM states: IDLE, WAIT_ACK.
  - IDLE: on a drop press with game_busy=0, drop_req goes to 1 and drop_col latches cursor_col in the same edge; go to WAIT_ACK.
  - IDLE: a drop press with game_busy=1 is discarded, not queued.
  - IDLE: drop_ack is ignored.
  - WAIT_ACK: drop_req and drop_col are held. The cycle drop_ack=1 is sampled, drop_req clears at that edge; return to IDLE.
  - WAIT_ACK: left/right/drop presses are ignored, but prev registers still track the switches, so a switch held through WAIT_ACK does not fire on return.
- drop_ack in the same cycle drop_req first rises is impossible, since it is sampled the following cycle at the earliest.
- Reset mid-handshake drops the request immediately (drop_req=0 next cycle).
- Counter width: $clog2 of max(REPEAT_DELAY,REPEAT_RATE)+1. No overflow is possible.

Optional Feature:
- Macro MOVE_INPUT_WRAP_EN.
- When defined: left at column 0 goes to NUM_COLS-1, and right at NUM_COLS-1 goes to 0. This applies to both presses and auto-repeats.
- When undefined: the cursor saturates at both ends and the move is silently dropped.

Decomposition:
- Shared package connect4_pkg holds:
  - NUM_COLS and COL_W constants.
  - FSM state typedef {IDLE, WAIT_ACK}, reused by the game logic for its ack side.
- One natural sub-module: btn_edge_repeat. It does per-direction edge detect plus the repeat counter and outputs a single-cycle step pulse.
- Drop uses the edge-detect path only (repeat disabled).

Test Plan (REPEAT_DELAY=8, REPEAT_RATE=4 for simulation):
- Reset with btn_right held high, then hold 3 cycles → cursor_col stays 3 and no move occurs until release and re-press. Re-press → cursor_col=4 one cycle later.
- Press left 4 single-cycle times from 3 → cursor_col 2,1,0,0. With MOVE_INPUT_WRAP_EN, the last press gives 6.
- Hold right 20 cycles from 0 → move at press (1), then at +8 (2), +12 (3), +16 (4), +20 (5).
- Press left and right in the same cycle → cursor unchanged. Drop+left in the same cycle → drop_req=1, drop_col=old cursor, cursor unchanged.
- Drop at col 5, game_busy=0 → drop_req=1, drop_col=5. Hold drop_ack=0 for 5 cycles while pressing left → drop_req holds and cursor stays 5. Then drop_ack=1 → drop_req=0 next cycle and state is IDLE.
- Drop press while game_busy=1 → no drop_req, even after game_busy falls. Assert rst during WAIT_ACK → drop_req=0 and cursor_col=3 next cycle.

Source files
------------

// File: rtl/connect4_pkg.sv
// Shared Connect4 constants and the drop-handshake state type used by both
// the input controller and the game logic on the ack side.
package connect4_pkg;

    localparam int NUM_COLS = 7;
    localparam int COL_W    = 3;

    typedef enum logic [0:0] {
        IDLE,
        WAIT_ACK
    } ack_state_e;

endpackage

// File: rtl/btn_edge_repeat.sv
// Rising-edge detector for one debounced switch, with optional hold-to-repeat.
// step pulses for one cycle on a fresh press and on each auto-repeat.
module btn_edge_repeat #(
    parameter bit REPEAT_EN    = 1'b1,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    input  logic enable,
    output logic step
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    logic             prev_q;
    logic             armed_q;
    logic             rep_q;
    logic [CNT_W-1:0] cnt_q;
    logic             press;
    logic             fire;

    assign press = btn & ~prev_q;
    assign fire  = REPEAT_EN && armed_q && btn &&
                   (cnt_q == (rep_q ? RATE_LAST : DELAY_LAST));
    assign step  = enable & (press | fire);

    // Repeat only follows a press this block accepted, so a switch held
    // through reset or through a suppressed window never starts repeating.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            prev_q  <= 1'b1;
            armed_q <= 1'b0;
            rep_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            prev_q <= btn;
            if (!enable || !btn) begin
                armed_q <= 1'b0;
                rep_q   <= 1'b0;
                cnt_q   <= '0;
            end else if (press) begin
                armed_q <= 1'b1;
                rep_q   <= 1'b0;
                cnt_q   <= '0;
            end else if (armed_q && REPEAT_EN) begin
                if (fire) begin
                    rep_q <= 1'b1;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/move_input_ctrl.sv
// Connect4 switch-to-command front end: cursor column plus drop req/ack.
// Define MOVE_INPUT_WRAP_EN to wrap the cursor at the board edges.
module move_input_ctrl
    import connect4_pkg::*;
#(
    parameter int NUM_COLS     = connect4_pkg::NUM_COLS,
    parameter int COL_W        = connect4_pkg::COL_W,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 10000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             btn_drop,
    input  logic             game_busy,
    input  logic             drop_ack,
    output logic [COL_W-1:0] cursor_col,
    output logic             drop_req,
    output logic [COL_W-1:0] drop_col
);

`ifdef MOVE_INPUT_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    localparam logic [COL_W-1:0] MAX_COL   = COL_W'(NUM_COLS - 1);
    localparam logic [COL_W-1:0] RESET_COL = COL_W'(NUM_COLS / 2);

    ack_state_e       state_q, state_d;
    logic [COL_W-1:0] cursor_q, cursor_d;
    logic [COL_W-1:0] drop_col_q, drop_col_d;
    logic             left_step, right_step, drop_step;
    logic             move_en;

    // Drop outranks direction, and both directions together cancel out.
    assign move_en = (state_q == IDLE) & ~(btn_left & btn_right) & ~drop_step;

    btn_edge_repeat #(
        .REPEAT_EN   (1'b1),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
    ) u_left (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_left),
        .enable(move_en),
        .step  (left_step)
    );

    btn_edge_repeat #(
        .REPEAT_EN   (1'b1),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
    ) u_right (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_right),
        .enable(move_en),
        .step  (right_step)
    );

    btn_edge_repeat #(
        .REPEAT_EN   (1'b0),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
    ) u_drop (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_drop),
        .enable(1'b1),
        .step  (drop_step)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cursor_q   <= RESET_COL;
            drop_col_q <= '0;
        end else begin
            state_q    <= state_d;
            cursor_q   <= cursor_d;
            drop_col_q <= drop_col_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d    = state_q;
        cursor_d   = cursor_q;
        drop_col_d = drop_col_q;
        case (state_q)
            IDLE: begin
                if (drop_step && !game_busy) begin
                    state_d    = WAIT_ACK;
                    drop_col_d = cursor_q;
                end else if (left_step) begin
                    if (cursor_q != '0) cursor_d = cursor_q - 1'b1;
                    else if (WRAP_EN)   cursor_d = MAX_COL;
                end else if (right_step) begin
                    if (cursor_q != MAX_COL) cursor_d = cursor_q + 1'b1;
                    else if (WRAP_EN)        cursor_d = '0;
                end
            end
            WAIT_ACK: begin
                if (drop_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cursor_col = cursor_q;
    assign drop_req   = (state_q == WAIT_ACK);
    assign drop_col   = drop_col_q;

endmodule

// File: tb/tb_move_input_ctrl.sv
// Directed bench for move_input_ctrl with short repeat timing (delay 8, rate 4).
module tb_move_input_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_left, btn_right, btn_drop, game_busy, drop_ack;
    logic [2:0] cursor_col;
    logic       drop_req;
    logic [2:0] drop_col;

    int n_checks = 0;
    int n_pass   = 0;

    move_input_ctrl #(
        .NUM_COLS    (7),
        .COL_W       (3),
        .REPEAT_DELAY(8),
        .REPEAT_RATE (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_drop  (btn_drop),
        .game_busy (game_busy),
        .drop_ack  (drop_ack),
        .cursor_col(cursor_col),
        .drop_req  (drop_req),
        .drop_col  (drop_col)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    int exp_col;

    initial begin
        rst = 1'b1; btn_left = 0; btn_right = 1; btn_drop = 0; game_busy = 0; drop_ack = 0;
        tick(2);
        check("reset_cursor", cursor_col, 3);
        check("reset_req", drop_req, 0);
        check("reset_dcol", drop_col, 0);

        // Right held through reset must not move until released and re-pressed.
        rst = 1'b0;
        tick(3);
        check("held_thru_reset", cursor_col, 3);
        btn_right = 0; tick();
        check("release_no_move", cursor_col, 3);
        btn_right = 1; tick();
        check("repress_right", cursor_col, 4);
        btn_right = 0; tick();

        // Back to 3, then four single left presses.
        btn_left = 1; tick(); btn_left = 0; tick();
        check("left_to_3", cursor_col, 3);
        btn_left = 1; tick(); check("left_2", cursor_col, 2); btn_left = 0; tick();
        btn_left = 1; tick(); check("left_1", cursor_col, 1); btn_left = 0; tick();
        btn_left = 1; tick(); check("left_0", cursor_col, 0); btn_left = 0; tick();
        btn_left = 1; tick();
`ifdef MOVE_INPUT_WRAP_EN
        check("left_wrap", cursor_col, 6);
        btn_left = 0; tick();
        btn_right = 1; tick(); check("right_wrap", cursor_col, 0); btn_right = 0; tick();
`else
        check("left_sat", cursor_col, 0);
        btn_left = 0; tick();
`endif

        // Hold right for cycles 0..20: moves at 0, 8, 12, 16, 20.
        btn_right = 1;
        exp_col = 0;
        for (int k = 0; k <= 20; k++) begin
            tick();
            if (k == 0 || k == 8 || k == 12 || k == 16 || k == 20) exp_col++;
            check($sformatf("repeat_c%0d", k), cursor_col, exp_col);
        end
        btn_right = 0; tick(2);
        check("repeat_release", cursor_col, 5);

        // Both directions at once: no move.
        btn_left = 1; btn_right = 1; tick();
        check("both_no_move", cursor_col, 5);
        btn_left = 0; btn_right = 0; tick();

        // Drop + left together: drop wins, cursor unchanged.
        btn_drop = 1; btn_left = 1; tick();
        check("dl_req", drop_req, 1);
        check("dl_col", drop_col, 5);
        check("dl_cursor", cursor_col, 5);
        btn_drop = 0; btn_left = 0; tick();
        drop_ack = 1; tick();
        check("dl_ack_clear", drop_req, 0);
        drop_ack = 0; tick();

        // Drop at 5, then left presses while waiting for ack are ignored.
        btn_drop = 1; tick();
        check("drop_req", drop_req, 1);
        check("drop_col", drop_col, 5);
        btn_drop = 0;
        for (int k = 0; k < 5; k++) begin
            btn_left = (k % 2 == 0); tick();
            check($sformatf("wait_req%0d", k), drop_req, 1);
            check($sformatf("wait_cur%0d", k), cursor_col, 5);
        end
        check("wait_dcol", drop_col, 5);
        // btn_left is high here and stays held across the ack.
        drop_ack = 1; tick();
        check("ack_clear", drop_req, 0);
        drop_ack = 0; tick();
        check("held_left_no_fire", cursor_col, 5);
        btn_left = 0; tick();

        // drop_ack in IDLE is ignored.
        drop_ack = 1; tick();
        check("idle_ack", drop_req, 0);
        drop_ack = 0; tick();

        // Busy drop is discarded, not queued.
        game_busy = 1; btn_drop = 1; tick();
        check("busy_drop", drop_req, 0);
        btn_drop = 0; game_busy = 0; tick();
        check("busy_no_queue", drop_req, 0);
        tick();
        check("busy_no_queue2", drop_req, 0);

        // Reset mid-handshake.
        btn_right = 1; tick(); btn_right = 0; tick();
        check("pre_rst_cursor", cursor_col, 6);
        btn_drop = 1; tick(); btn_drop = 0;
        check("pre_rst_req", drop_req, 1);
        rst = 1; tick();
        check("rst_req", drop_req, 0);
        check("rst_cursor", cursor_col, 3);
        check("rst_dcol", drop_col, 0);
        rst = 0; tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
